// File: rtl/corner_pipeline_sequencer.sv
// corner_pipeline_sequencer
// Frames the input of a corner-detection pipeline and collects its results.
// Each frame runs as follows:
//   - Pixels are accepted in raster order.
//   - The pipeline is then flushed with zero luma until every pixel has emerged.
//   - After a warm-up of LAT_ROWS*W+LAT_COLS valid cycles, each pipeline flag
//     is mapped back to an output coordinate.
//   - Flagged coordinates inside the border margin are queued in a
//     first-word-fall-through FIFO.
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   start                  frame start pulse (honoured only while idle)
//   r_width, r_height      frame dimensions, latched at start
//   pix_valid / pix_ready  upstream pixel handshake
//   pipe_valid             pipeline in_valid
//   pipe_flush             selects zero luma into the pipeline
//   pipe_is_corner         registered corner flag from the pipeline
//   corner_valid / corner_ready, corner_x, corner_y
//                          corner output stream
//   busy, done             frame in progress; one-cycle end-of-frame pulse
//   overflow               sticky: a corner was dropped on a full FIFO
//   corner_count           saturating count of queued corners
module corner_pipeline_sequencer #(
    parameter int COORD_BITS = 11,
    parameter int LAT_ROWS   = 5,
    parameter int LAT_COLS   = 16,
    parameter int BORDER     = 3,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [COORD_BITS-1:0] r_width,
    input  logic [COORD_BITS-1:0] r_height,
    input  logic                  pix_valid,
    output logic                  pix_ready,
    output logic                  pipe_valid,
    output logic                  pipe_flush,
    input  logic                  pipe_is_corner,
    output logic                  corner_valid,
    input  logic                  corner_ready,
    output logic [COORD_BITS-1:0] corner_x,
    output logic [COORD_BITS-1:0] corner_y,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [15:0]           corner_count
);

    localparam int LAT_W = COORD_BITS + 8;
    localparam int CB    = COORD_BITS + 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam logic [CB-1:0]    BORDER_C   = CB'(BORDER);
    localparam logic [LAT_W-1:0] LAT_ROWS_C = LAT_W'(LAT_ROWS);
    localparam logic [LAT_W-1:0] LAT_COLS_C = LAT_W'(LAT_COLS);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_FLUSH = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t                  state_r, state_n;
    logic [COORD_BITS-1:0]   w_r, h_r;
    logic [COORD_BITS-1:0]   ix_r, iy_r, ox_r, oy_r;
    logic                    eval_on_r;
    logic [LAT_W-1:0]        warm_r, flush_cnt_r;
    logic [COORD_BITS-1:0]   mem_x_r [FIFO_DEPTH];
    logic [COORD_BITS-1:0]   mem_y_r [FIFO_DEPTH];
    logic [AW:0]             wr_ptr_r, rd_ptr_r;
    logic                    overflow_r;
    logic [15:0]             count_r;

    logic [LAT_W-1:0]        lat_total_s;
    logic                    frame_start_s, accept_s, last_in_s;
    logic                    warm_done_s, eval_s, last_eval_s, in_border_s;
    logic                    push_s, pop_s, push_ok_s, full_s, empty_s;

    // Pipeline latency in cycles, kept at full width so large frames are not truncated.
    assign lat_total_s   = (LAT_ROWS_C * {8'd0, w_r}) + LAT_COLS_C;

    assign frame_start_s = (state_r == ST_IDLE) && start;
    assign accept_s      = (state_r == ST_RUN) && pix_valid;
    assign last_in_s     = (ix_r == (w_r - COORD_BITS'(1))) && (iy_r == (h_r - COORD_BITS'(1)));
    assign pipe_valid    = accept_s || (state_r == ST_FLUSH);

    // The output coordinate lags the input by the pipeline latency. Counting
    // warm-up in pipe_valid cycles keeps the mapping exact under input stalls.
    assign warm_done_s   = (warm_r >= lat_total_s);
    assign eval_s        = pipe_valid && eval_on_r && warm_done_s;
    assign last_eval_s   = eval_s && (ox_r == (w_r - COORD_BITS'(1)))
                                  && (oy_r == (h_r - COORD_BITS'(1)));
    // Compare one bit wider so narrow frames (W < BORDER) cannot underflow.
    assign in_border_s   = ({1'b0, ox_r} >= BORDER_C) && (({1'b0, ox_r} + BORDER_C) < {1'b0, w_r})
                        && ({1'b0, oy_r} >= BORDER_C) && (({1'b0, oy_r} + BORDER_C) < {1'b0, h_r});

    assign empty_s       = (wr_ptr_r == rd_ptr_r);
    assign full_s        = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
    assign pop_s         = !empty_s && corner_ready;
    assign push_s        = eval_s && pipe_is_corner && in_border_s;
    // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
    assign push_ok_s     = push_s && (!full_s || pop_s);

    assign corner_valid  = !empty_s;
    assign corner_x      = empty_s ? {COORD_BITS{1'b0}} : mem_x_r[rd_ptr_r[AW-1:0]];
    assign corner_y      = empty_s ? {COORD_BITS{1'b0}} : mem_y_r[rd_ptr_r[AW-1:0]];
    assign overflow      = overflow_r;
    assign corner_count  = count_r;

    // Next-state and state-decoded control outputs.
    always_comb begin
        state_n    = state_r;
        pix_ready  = 1'b0;
        pipe_flush = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if ((r_width == {COORD_BITS{1'b0}}) || (r_height == {COORD_BITS{1'b0}})) begin
                        state_n = ST_DONE;
                    end else begin
                        state_n = ST_RUN;
                    end
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_RUN: begin
                pix_ready = 1'b1;
                busy      = 1'b1;
                if (accept_s && last_in_s) begin
                    state_n = ST_FLUSH;
                end else begin
                    state_n = ST_RUN;
                end
            end
            ST_FLUSH: begin
                pipe_flush = 1'b1;
                busy       = 1'b1;
                if ((flush_cnt_r + LAT_W'(1)) >= lat_total_s) begin
                    state_n = ST_DRAIN;
                end else begin
                    state_n = ST_FLUSH;
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (empty_s) begin
                    state_n = ST_DONE;
                end else begin
                    state_n = ST_DRAIN;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State register, frame geometry, and the input/output coordinate trackers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            w_r         <= {COORD_BITS{1'b0}};
            h_r         <= {COORD_BITS{1'b0}};
            ix_r        <= {COORD_BITS{1'b0}};
            iy_r        <= {COORD_BITS{1'b0}};
            ox_r        <= {COORD_BITS{1'b0}};
            oy_r        <= {COORD_BITS{1'b0}};
            eval_on_r   <= 1'b0;
            warm_r      <= {LAT_W{1'b0}};
            flush_cnt_r <= {LAT_W{1'b0}};
        end else begin
            state_r <= state_n;
            if (frame_start_s) begin
                w_r         <= r_width;
                h_r         <= r_height;
                ix_r        <= {COORD_BITS{1'b0}};
                iy_r        <= {COORD_BITS{1'b0}};
                ox_r        <= {COORD_BITS{1'b0}};
                oy_r        <= {COORD_BITS{1'b0}};
                eval_on_r   <= (r_width != {COORD_BITS{1'b0}}) && (r_height != {COORD_BITS{1'b0}});
                warm_r      <= {LAT_W{1'b0}};
                flush_cnt_r <= {LAT_W{1'b0}};
            end else begin
                if (accept_s) begin
                    if (ix_r == (w_r - COORD_BITS'(1))) begin
                        ix_r <= {COORD_BITS{1'b0}};
                        iy_r <= iy_r + COORD_BITS'(1);
                    end else begin
                        ix_r <= ix_r + COORD_BITS'(1);
                    end
                end
                if (pipe_valid && !warm_done_s) begin
                    warm_r <= warm_r + LAT_W'(1);
                end
                if (state_r == ST_FLUSH) begin
                    flush_cnt_r <= flush_cnt_r + LAT_W'(1);
                end
                if (eval_s) begin
                    if (ox_r == (w_r - COORD_BITS'(1))) begin
                        ox_r <= {COORD_BITS{1'b0}};
                        oy_r <= oy_r + COORD_BITS'(1);
                    end else begin
                        ox_r <= ox_r + COORD_BITS'(1);
                    end
                    if (last_eval_s) begin
                        eval_on_r <= 1'b0;
                    end
                end
            end
        end
    end

    // FIFO pointers, sticky overflow, and the saturating corner counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r   <= {(AW+1){1'b0}};
            rd_ptr_r   <= {(AW+1){1'b0}};
            overflow_r <= 1'b0;
            count_r    <= 16'd0;
        end else if (frame_start_s) begin
            overflow_r <= 1'b0;
            count_r    <= 16'd0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
                if (count_r != 16'hFFFF) begin
                    count_r <= count_r + 16'd1;
                end
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
            end
            if (push_s && full_s && !pop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // FIFO storage; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_x_r[wr_ptr_r[AW-1:0]] <= ox_r;
            mem_y_r[wr_ptr_r[AW-1:0]] <= oy_r;
        end
    end

endmodule

// File: tb/tb_corner_pipeline_sequencer.sv
// Self-checking bench for corner_pipeline_sequencer.
// The pipeline itself is modelled by a counter of pipe_valid cycles. Once the
// latency has elapsed, it returns the flag that the test planted for that
// raster position. Expected corners are pushed into a queue when a test is set
// up. A forked monitor pops the queue and compares on every corner handshake.
module tb_corner_pipeline_sequencer;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
    } xy_t;

    logic        clk = 1'b0;
    logic        reset, start, pix_valid, corner_ready, pipe_is_corner;
    logic [10:0] r_width, r_height;
    logic        pix_ready, pipe_valid, pipe_flush, corner_valid, busy, done, overflow;
    logic [10:0] corner_x, corner_y;
    logic [15:0] corner_count;

    int   n_cmp  = 0;
    int   n_fail = 0;
    xy_t  exp_q[$];
    bit   flags [0:1023];
    int   cur_w  = 8;
    int   pv_cnt = 0;
    int   run_pv = 0;
    int   flush_pv = 0;
    int   done_cnt = 0;

    always #5 clk = ~clk;

    corner_pipeline_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .r_width        (r_width),
        .r_height       (r_height),
        .pix_valid      (pix_valid),
        .pix_ready      (pix_ready),
        .pipe_valid     (pipe_valid),
        .pipe_flush     (pipe_flush),
        .pipe_is_corner (pipe_is_corner),
        .corner_valid   (corner_valid),
        .corner_ready   (corner_ready),
        .corner_x       (corner_x),
        .corner_y       (corner_y),
        .busy           (busy),
        .done           (done),
        .overflow       (overflow),
        .corner_count   (corner_count)
    );

    // Pipeline model: count the pipe_valid cycles issued since the frame start.
    always @(posedge clk) begin
        if (reset || start) pv_cnt <= 0;
        else if (pipe_valid) pv_cnt <= pv_cnt + 1;
    end

    // Pipeline model: the flag for raster index (pv_cnt - latency).
    always_comb begin
        pipe_is_corner = 1'b0;
        if ((pv_cnt >= (5 * cur_w + 16)) && ((pv_cnt - (5 * cur_w + 16)) < 1024))
            pipe_is_corner = flags[pv_cnt - (5 * cur_w + 16)];
        else
            pipe_is_corner = 1'b0;
    end

    // Activity counters sampled on the falling edge.
    always @(negedge clk) begin
        if (pipe_valid && !pipe_flush) run_pv <= run_pv + 1;
        if (pipe_valid && pipe_flush)  flush_pv <= flush_pv + 1;
        if (done)                      done_cnt <= done_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic monitor_loop();
        forever begin
            @(negedge clk);
            if (!reset && corner_valid && corner_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_corner", 1, 0);
                end else begin
                    xy_t e;
                    e = exp_q.pop_front();
                    check("corner_x", int'(corner_x), int'(e.x));
                    check("corner_y", int'(corner_y), int'(e.y));
                end
            end
        end
    endtask

    task automatic clear_flags();
        for (int i = 0; i < 1024; i++) flags[i] = 1'b0;
    endtask

    task automatic set_flag(input int x, input int y, input int w);
        flags[y * w + x] = 1'b1;
    endtask

    task automatic expect_corner(input int x, input int y);
        xy_t e;
        e.x = 11'(x);
        e.y = 11'(y);
        exp_q.push_back(e);
    endtask

    // Called at posedge+1; returns at posedge+1 with the frame in RUN.
    task automatic start_frame(input int w, input int h);
        cur_w    = w;
        r_width  = 11'(w);
        r_height = 11'(h);
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic feed(input int n, input bit toggle);
        int acc = 0;
        int cyc = 0;
        bit hs;
        while (acc < n && cyc < 5000) begin
            pix_valid = toggle ? ((cyc % 2) == 0) : 1'b1;
            @(negedge clk);
            hs = pix_valid && pix_ready;
            @(posedge clk);
            #1;
            if (hs) acc++;
            cyc++;
        end
        pix_valid = 1'b0;
        if (acc < n) check("feed_timeout", acc, n);
    endtask

    task automatic wait_done(input int budget);
        int c = 0;
        bit seen = 1'b0;
        while (!seen && c < budget) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            c++;
        end
        check("done_seen", int'(seen), 1);
        if (seen) begin
            @(negedge clk);
            check("done_pulse_width", int'(done), 0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rp, fp, dc;
        reset = 1'b1; start = 1'b0; pix_valid = 1'b0; corner_ready = 1'b1;
        r_width = 11'd0; r_height = 11'd0;
        clear_flags();
        fork
            monitor_loop();
        join_none
        repeat (2) @(posedge clk);
        #1;
        // Reset state, sampled while reset is still asserted.
        check("rst_pix_ready", int'(pix_ready), 0);
        check("rst_pipe_valid", int'(pipe_valid), 0);
        check("rst_pipe_flush", int'(pipe_flush), 0);
        check("rst_corner_valid", int'(corner_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_corner_xy", int'({corner_x, corner_y}), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_corner_count", int'(corner_count), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // 8x6 frame, no corners: 48 input and 56 flush cycles.
        clear_flags();
        rp = run_pv; fp = flush_pv; dc = done_cnt;
        start_frame(8, 6);
        check("run_busy", int'(busy), 1);
        check("run_pix_ready", int'(pix_ready), 1);
        feed(48, 1'b0);
        wait_done(200);
        check("run_pipe_valid_cycles", run_pv - rp, 48);
        check("flush_pipe_valid_cycles", flush_pv - fp, 56);
        check("done_count_8x6", done_cnt - dc, 1);
        check("count_8x6", int'(corner_count), 0);
        check("busy_after_done", int'(busy), 0);

        // 8x8: (4,4) inside the margin, (1,4) outside it.
        clear_flags();
        set_flag(4, 4, 8);
        set_flag(1, 4, 8);
        expect_corner(4, 4);
        start_frame(8, 8);
        feed(64, 1'b0);
        wait_done(300);
        check("count_8x8", int'(corner_count), 1);
        check("queue_empty_8x8", exp_q.size(), 0);

        // 16x16 with pix_valid toggling; the edge cases at x/y = 2, 3, 12, 13.
        clear_flags();
        set_flag(3, 3, 16);   set_flag(12, 3, 16);  set_flag(2, 5, 16);
        set_flag(13, 4, 16);  set_flag(7, 9, 16);   set_flag(12, 12, 16);
        set_flag(8, 15, 16);  set_flag(5, 13, 16);
        expect_corner(3, 3);  expect_corner(12, 3);
        expect_corner(7, 9);  expect_corner(12, 12);
        start_frame(16, 16);
        feed(256, 1'b1);
        wait_done(600);
        check("count_16x16", int'(corner_count), 4);
        check("queue_empty_16x16", exp_q.size(), 0);

        // 20 qualifying corners while corner_ready=0: 16 kept, 4 dropped.
        clear_flags();
        for (int x = 3; x <= 12; x++) set_flag(x, 4, 16);
        for (int x = 3; x <= 12; x++) set_flag(x, 5, 16);
        for (int x = 3; x <= 12; x++) expect_corner(x, 4);
        for (int x = 3; x <= 8; x++)  expect_corner(x, 5);
        corner_ready = 1'b0;
        dc = done_cnt;
        start_frame(16, 16);
        feed(256, 1'b0);
        repeat (120) @(posedge clk);
        #1;
        check("ovf_overflow", int'(overflow), 1);
        check("ovf_count", int'(corner_count), 16);
        check("ovf_busy_drain", int'(busy), 1);
        check("ovf_corner_valid", int'(corner_valid), 1);
        check("ovf_head_x", int'(corner_x), 3);
        check("ovf_head_y", int'(corner_y), 4);
        check("ovf_no_done_yet", done_cnt - dc, 0);
        repeat (3) @(posedge clk);
        #1;
        check("ovf_head_x_stable", int'(corner_x), 3);
        check("ovf_head_y_stable", int'(corner_y), 4);
        corner_ready = 1'b1;
        wait_done(100);
        check("ovf_overflow_sticky", int'(overflow), 1);
        check("queue_empty_ovf", exp_q.size(), 0);

        // Reset after 20 pixels of an 8x8 frame, then a clean frame.
        clear_flags();
        dc = done_cnt;
        start_frame(8, 8);
        feed(20, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_corner_valid", int'(corner_valid), 0);
        check("abort_pix_ready", int'(pix_ready), 0);
        check("abort_count", int'(corner_count), 0);
        repeat (5) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt - dc, 0);
        set_flag(3, 4, 8);
        set_flag(5, 4, 8);
        expect_corner(3, 4);
        start_frame(8, 8);
        feed(64, 1'b0);
        wait_done(300);
        check("count_after_abort", int'(corner_count), 1);
        check("queue_empty_abort", exp_q.size(), 0);

        // Zero width: DONE on the next cycle with no pipeline activity.
        rp = run_pv; fp = flush_pv;
        r_width = 11'd0; r_height = 11'd5; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("w0_done", int'(done), 1);
        check("w0_busy", int'(busy), 0);
        @(posedge clk);
        #1;
        check("w0_done_drop", int'(done), 0);
        check("w0_pipe_valid_cycles", (run_pv - rp) + (flush_pv - fp), 0);

        repeat (3) @(posedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/corner_pipeline_sequencer.md
CORNER_PIPELINE_SEQUENCER -- requirements
Module: corner_pipeline_sequencer

Interface
REQ-001 SHALL have parameter COORD_BITS, default 11; coordinate and width/height width.
REQ-002 SHALL have parameter LAT_ROWS, default 5; corner pipeline row latency.
REQ-003 SHALL have parameter LAT_COLS, default 16; corner pipeline clock latency beyond LAT_ROWS rows.
REQ-004 SHALL have parameter BORDER, default 3; suppressed margin in pixels on every image edge.
REQ-005 SHALL have parameter FIFO_DEPTH, default 16 (power of 2); corner output FIFO entries.
REQ-006 SHALL have ports: clk in 1, clock; reset in 1, one clock, synchronous, active-high.
REQ-007 SHALL have ports: start in 1, frame start pulse; r_width in COORD_BITS; r_height in COORD_BITS.
REQ-008 SHALL have ports: pix_valid in 1; pix_ready out 1; upstream pixel handshake.
REQ-009 SHALL have ports: pipe_valid out 1, drives pipeline in_valid; pipe_flush out 1, selects zero luma into pipeline.
REQ-010 SHALL have port pipe_is_corner in 1, registered corner flag from pipeline.
REQ-011 SHALL have ports: corner_valid out 1; corner_ready in 1; corner_x, corner_y out COORD_BITS each.
REQ-012 SHALL have ports: busy out 1; done out 1 (pulse); overflow out 1 (sticky); corner_count out 16.

Function
REQ-013 SHALL implement states IDLE, RUN, FLUSH, DRAIN, DONE.
REQ-014 IDLE: start=1 latches r_width/r_height into W/H and clears counters, overflow, corner_count; W=0 or H=0 -> DONE, else -> RUN.
REQ-015 start outside IDLE SHALL be ignored.
REQ-016 RUN: pix_ready=1; pipe_valid=pix_valid&&pix_ready; pipe_flush=0; input coords ix/iy advance per accepted pixel, ix wraps at W-1 incrementing iy.
REQ-017 RUN -> FLUSH on acceptance of pixel (W-1,H-1).
REQ-018 FLUSH: pix_ready=0; pipe_valid=1, pipe_flush=1 every cycle for exactly LAT_ROWS*W+LAT_COLS cycles, then -> DRAIN.
REQ-019 Warm-up counter SHALL count pipe_valid cycles; output coords ox/oy advance only on pipe_valid cycles once count >= LAT_ROWS*W+LAT_COLS.
REQ-020 On each such cycle pipe_is_corner SHALL be taken as the flag for (ox,oy); ox wraps at W-1 incrementing oy.
REQ-021 Corner SHALL be pushed as (ox,oy) only if pipe_is_corner=1 and BORDER<=ox<W-BORDER and BORDER<=oy<H-BORDER.
REQ-022 Output-coordinate evaluation SHALL stop after (W-1,H-1); exactly W*H positions evaluated per frame.
REQ-023 Push with FIFO full and no same-cycle pop SHALL drop the corner and set overflow; full with same-cycle pop SHALL accept.
REQ-024 corner_count SHALL increment per accepted push, saturating at 16'hFFFF.
REQ-025 FIFO output SHALL be first-word-fall-through: corner_valid=!empty; pop on corner_valid&&corner_ready; corner_x/y stable while corner_valid&&!corner_ready.
REQ-026 Corner output backpressure SHALL never stall pipe_valid.
REQ-027 DRAIN -> DONE when FIFO empty; DONE asserts done=1 for one cycle, -> IDLE.
REQ-028 busy=1 in RUN, FLUSH, DRAIN; 0 in IDLE, DONE.
REQ-029 Products LAT_ROWS*W+LAT_COLS SHALL be computed at full width (COORD_BITS+8 bits) without truncation.

Reset
REQ-030 reset SHALL force IDLE, empty FIFO, clear all counters and overflow, corner_count=0.
REQ-031 During/after reset: pix_ready=0, pipe_valid=0, pipe_flush=0, corner_valid=0, busy=0, done=0, corner_x=corner_y=0.
REQ-032 reset mid-frame SHALL abort frame; no done pulse; queued corners discarded.

Verification
REQ-033 W=8,H=6, 48 pixels back-to-back, pipe_is_corner=0 -> exactly 48 RUN + 56 FLUSH pipe_valid cycles, done 1 cycle later, corner_count=0.
REQ-034 W=8,H=8, pipe_is_corner=1 only on evaluation of (4,4) and (1,4) -> single output (4,4), corner_count=1.
REQ-035 W=16,H=16, pix_valid toggling 50% -> ox/oy evaluation sequence unchanged, only (x,y) flagged appear, order preserved.
REQ-036 FIFO_DEPTH=16, corner_ready=0, 20 qualifying corners -> 16 stored, overflow=1, corner_count=16; then ready=1 drains 16 in order.
REQ-037 reset asserted mid-RUN at pixel 20 -> next cycle IDLE, corner_valid=0, busy=0; new start runs clean frame.
REQ-038 start with r_width=0 -> DONE next cycle, done pulse, zero pipe_valid cycles.
